// File: rtl/reg64_byte_packer.sv
// reg64_byte_packer: packs a valid/ready byte stream little-endian into 64-bit write
// commands for the register stage and forwards read requests. Optional: PACKER_TIMEOUT_EN.
module reg64_byte_packer #(
    parameter logic [7:0]  FILL_BYTE = 8'h00,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    input  logic        RdReq,
    input  logic        Flush,
    output logic [63:0] WordOut,
    output logic        RegEn,
    output logic        RegRead,
    output logic [3:0]  ByteCount,
    output logic        Busy
);

    typedef enum logic [2:0] {
        S_PRIME,
        S_IDLE,
        S_FILL,
        S_ISSUE_WR,
        S_ISSUE_RD
    } state_t;

    state_t      r_state;
    logic [63:0] r_word;
    logic [63:0] r_word_out;
    logic [3:0]  r_byte_cnt;
    logic        r_reg_en;
    logic        r_reg_read;
    logic        r_busy;
    logic        r_rd_pend;

    logic        w_accept;
    logic        w_last_byte;
    logic        w_timeout;
    logic        w_flush;
    logic [3:0]  w_pad_from;
    logic [63:0] w_packed;
    logic [63:0] w_padded;

    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range
        $error("reg64_byte_packer: TIMEOUT must be within 2..255");
    end

    assign ByteReady   = ((r_state == S_IDLE) && !RdReq) || (r_state == S_FILL);
    assign w_accept    = ByteValid && ByteReady;
    assign w_last_byte = (r_state == S_FILL) && w_accept && (r_byte_cnt == 4'd7);

`ifdef PACKER_TIMEOUT_EN
    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_idle_cnt;

    // Fires on the TIMEOUT-th consecutive FILL cycle without an accepted byte.
    assign w_timeout = (r_state == S_FILL) && !w_accept && (r_idle_cnt == IDLE_LIMIT);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_idle_cnt <= '0;
        end else if ((r_state == S_FILL) && !w_accept && !w_flush) begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
        end else begin
            r_idle_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_flush = (r_state == S_FILL) && (Flush || w_timeout);

    always_comb begin
        // NOTE: every variable gets a default before any condition, so no path
        // leaves one unassigned and no latch is inferred.
        w_packed   = r_word;
        w_pad_from = r_byte_cnt;
        if (w_accept) begin
            w_packed[8*r_byte_cnt[2:0] +: 8] = ByteIn;
            w_pad_from                       = r_byte_cnt + 4'd1;
        end
        w_padded = w_packed;
        for (int k = 0; k < 8; k++) begin
            if (k >= int'(w_pad_from)) begin
                w_padded[8*k +: 8] = FILL_BYTE;
            end
        end
    end

    // NOTE: non-blocking assignments make every register sample pre-edge values,
    // so the result does not depend on statement order inside the block.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= S_PRIME;
            r_word     <= '0;
            r_word_out <= '0;
            r_byte_cnt <= '0;
            r_reg_en   <= 1'b0;
            r_reg_read <= 1'b0;
            r_busy     <= 1'b1;
            r_rd_pend  <= 1'b0;
        end else begin
            r_reg_en   <= 1'b0;
            r_reg_read <= 1'b0;
            if (w_accept) begin
                r_word <= w_packed;
            end

            unique case (r_state)
                S_PRIME: begin
                    if (RdReq) begin
                        r_rd_pend <= 1'b1;
                    end
                    // First edge raises the prime pulse, the second retires it.
                    if (!r_reg_en) begin
                        r_reg_en   <= 1'b1;
                        r_word_out <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_IDLE: begin
                    // A read left pending from an earlier state yields to a byte.
                    if (RdReq || (r_rd_pend && !w_accept)) begin
                        r_state    <= S_ISSUE_RD;
                        r_reg_en   <= 1'b1;
                        r_reg_read <= 1'b1;
                        r_rd_pend  <= 1'b0;
                        r_busy     <= 1'b1;
                    end else if (w_accept) begin
                        r_state    <= S_FILL;
                        r_byte_cnt <= 4'd1;
                        r_busy     <= 1'b1;
                    end
                end

                S_FILL: begin
                    if (RdReq) begin
                        r_rd_pend <= 1'b1;
                    end
                    if (w_last_byte || w_flush) begin
                        r_state    <= S_ISSUE_WR;
                        r_word_out <= w_padded;
                        r_byte_cnt <= '0;
                        r_reg_en   <= 1'b1;
                    end else if (w_accept) begin
                        r_byte_cnt <= r_byte_cnt + 4'd1;
                    end
                end

                S_ISSUE_WR: begin
                    if (r_rd_pend || RdReq) begin
                        r_state    <= S_ISSUE_RD;
                        r_reg_en   <= 1'b1;
                        r_reg_read <= 1'b1;
                        r_rd_pend  <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_ISSUE_RD: begin
                    // A request arriving during the read merges into it.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_PRIME;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign WordOut   = r_word_out;
    assign RegEn     = r_reg_en;
    assign RegRead   = r_reg_read;
    assign ByteCount = r_byte_cnt;
    assign Busy      = r_busy;

endmodule
